// File: rtl/param_fsm_core.sv
// Multi-cycle accumulator controller: fetches one 8-bit instruction per handshake,
// runs it through a wait-stated memory port with timeout, and updates acc/flags/pc.
module param_fsm_core #(
  parameter int WIDTH       = 8,
  parameter int ADDR_W      = 8,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              in_clk,
  input  logic              in_restart_n,
  input  logic [7:0]        in_instruction,
  input  logic              in_instr_valid,
  output logic              out_instr_ready,
  output logic              out_mem_req,
  output logic              out_mem_we,
  output logic [ADDR_W-1:0] out_mem_addr,
  output logic [WIDTH-1:0]  out_mem_wdata,
  input  logic [WIDTH-1:0]  in_mem_rdata,
  input  logic              in_mem_ready,
  output logic [3:0]        out_state_main,
  output logic [WIDTH-1:0]  out_reg,
  output logic [ADDR_W-1:0] out_pc,
  output logic [1:0]        out_flags,
  output logic              out_err
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_REQ  = 4'd3,
    S_MEM_WAIT = 4'd4,
    S_EXEC     = 4'd5,
    S_WRITE    = 4'd6,
    S_BR_EVAL  = 4'd7,
    S_BR_TAKE  = 4'd8,
    S_DONE     = 4'd9
  } state_t;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_SUBI  = 4'b0011;
  localparam logic [3:0] OP_AND   = 4'b0100;
  localparam logic [3:0] OP_ANDI  = 4'b0101;
  localparam logic [3:0] OP_LOAD  = 4'b1010;
  localparam logic [3:0] OP_STORE = 4'b1011;
  localparam logic [3:0] OP_BEQ   = 4'b1100;
  localparam logic [3:0] OP_BNE   = 4'b1101;

  localparam int CNT_W = (MEM_TIMEOUT <= 1) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_t             state, state_next;
  logic [7:0]         instr;
  logic [WIDTH-1:0]   operand, acc, alu_res, alu_val, operand_b, imm_ext;
  logic [ADDR_W-1:0]  pc, mem_addr, off_sext;
  logic [CNT_W-1:0]   wait_cnt;
  logic               flag_c, flag_z, alu_c, alu_c_val, err;
  logic [WIDTH:0]     sum, diff;
  logic [3:0]         op;
  logic               is_imm, timeout_hit, branch_cond;

  always_comb begin
    op          = instr[7:4];
    is_imm      = (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_ANDI);
    imm_ext     = '0;
    imm_ext[3:0] = instr[3:0];
    off_sext    = {ADDR_W{instr[3]}};
    off_sext[3:0] = instr[3:0];
    operand_b   = is_imm ? imm_ext : operand;
    sum         = {1'b0, acc} + {1'b0, operand_b};
    diff        = {1'b0, acc} - {1'b0, operand_b};
    timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == CNT_LAST);
    branch_cond = (op == OP_BEQ) ? flag_z : ~flag_z;
    // Carry for SUB is "no borrow"; non-arithmetic ops keep the old carry.
    alu_val     = operand;
    alu_c_val   = flag_c;
    case (op)
      OP_ADD, OP_ADDI: begin alu_val = sum[WIDTH-1:0];  alu_c_val = sum[WIDTH];   end
      OP_SUB, OP_SUBI: begin alu_val = diff[WIDTH-1:0]; alu_c_val = ~diff[WIDTH]; end
      OP_AND, OP_ANDI: alu_val = acc & operand_b;
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   state_next = S_FETCH;
      S_FETCH:  if (in_instr_valid) state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND: state_next = S_MEM_REQ;
          OP_ADDI, OP_SUBI, OP_ANDI:                 state_next = S_EXEC;
          OP_BEQ, OP_BNE:                            state_next = S_BR_EVAL;
          default:                                   state_next = S_DONE;
        endcase
      end
      S_MEM_REQ: state_next = S_MEM_WAIT;
      // A ready arriving on the final timeout cycle still completes normally.
      S_MEM_WAIT: begin
        if (in_mem_ready)     state_next = (op == OP_STORE) ? S_DONE : S_EXEC;
        else if (timeout_hit) state_next = S_DONE;
      end
      S_EXEC:    state_next = S_WRITE;
      S_WRITE:   state_next = S_DONE;
      S_BR_EVAL: state_next = branch_cond ? S_BR_TAKE : S_DONE;
      S_BR_TAKE: state_next = S_FETCH;
      S_DONE:    state_next = S_FETCH;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (!in_restart_n) begin
      state    <= S_IDLE;
      instr    <= '0;
      operand  <= '0;
      acc      <= '0;
      alu_res  <= '0;
      alu_c    <= 1'b0;
      pc       <= '0;
      mem_addr <= '0;
      wait_cnt <= '0;
      flag_c   <= 1'b0;
      flag_z   <= 1'b0;
      err      <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        S_FETCH:  if (in_instr_valid) instr <= in_instruction;
        S_DECODE: if (state_next == S_MEM_REQ) mem_addr <= ADDR_W'(instr[3:0]);
        S_MEM_REQ: wait_cnt <= '0;
        S_MEM_WAIT: begin
          if (in_mem_ready) begin
            if (op != OP_STORE) operand <= in_mem_rdata;
          end else if (timeout_hit) begin
            err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_EXEC: begin
          alu_res <= alu_val;
          alu_c   <= alu_c_val;
        end
        S_WRITE: begin
          acc    <= alu_res;
          flag_z <= (alu_res == '0);
          flag_c <= alu_c;
        end
        S_BR_TAKE: pc <= pc + ADDR_W'(1) + off_sext;
        S_DONE:    pc <= pc + ADDR_W'(1);
        default: ;
      endcase
    end
  end

  assign out_instr_ready = (state == S_FETCH);
  assign out_mem_req     = (state == S_MEM_REQ);
  assign out_mem_we      = (state == S_MEM_REQ) && (op == OP_STORE);
  assign out_mem_addr    = mem_addr;
  assign out_mem_wdata   = acc;
  assign out_state_main  = state;
  assign out_reg         = acc;
  assign out_pc          = pc;
  assign out_flags       = {flag_c, flag_z};
  assign out_err         = err;

endmodule

// File: tb/tb_param_fsm_core.sv
// Bench for param_fsm_core: instruction table with scoreboard, plus reset corner cases.
module tb_param_fsm_core;

  logic       clk = 1'b0;
  logic       restart_n;
  logic [7:0] instruction;
  logic       instr_valid;
  logic       instr_ready;
  logic       mem_req, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_ready;
  logic [3:0] state_main;
  logic [7:0] acc, pc;
  logic [1:0] flags;
  logic       err;

  param_fsm_core #(.WIDTH(8), .ADDR_W(8), .MEM_TIMEOUT(4)) dut (
    .in_clk(clk), .in_restart_n(restart_n),
    .in_instruction(instruction), .in_instr_valid(instr_valid),
    .out_instr_ready(instr_ready), .out_mem_req(mem_req), .out_mem_we(mem_we),
    .out_mem_addr(mem_addr), .out_mem_wdata(mem_wdata),
    .in_mem_rdata(mem_rdata), .in_mem_ready(mem_ready),
    .out_state_main(state_main), .out_reg(acc), .out_pc(pc),
    .out_flags(flags), .out_err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] acc;
    logic [1:0] flags;
    logic [7:0] pc;
    logic       err;
    logic [7:0] cycles;
    logic [1:0] reqs;
  } exp_t;

  typedef struct {
    logic [7:0] instr;
    logic [7:0] rdata;
    int         delay;
    logic [7:0] acc;
    logic [1:0] flags;
    logic [7:0] pc;
    logic       err;
    int         cycles;
  } vec_t;

  localparam int NV = 21;
  vec_t       vecs [NV];
  exp_t       exp_q[$];
  logic [3:0] trace[$];
  int         tests_run = 0;
  int         tests_failed = 0;
  int         act_cycles, act_reqs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == 4'hA) || (op == 4'hB) || (op == 4'h0) || (op == 4'h2) || (op == 4'h4);
  endfunction

  // Drives one instruction starting in FETCH at a negedge and serves the memory port
  // until FETCH is reached again. Valid stays high with junk bits outside FETCH.
  task automatic run_instr(input logic [7:0] ins, input logic [7:0] rdata, input int delay,
                           input logic [7:0] exp_wdata);
    int waits;
    waits = 0;
    act_cycles = 0;
    act_reqs = 0;
    trace.delete();
    trace.push_back(state_main);
    instruction = ins;
    instr_valid = 1'b1;
    do begin
      @(posedge clk);
      @(negedge clk);
      act_cycles++;
      trace.push_back(state_main);
      instruction = 8'($urandom_range(0, 255));
      instr_valid = 1'b1;
      mem_ready = 1'b0;
      mem_rdata = 8'($urandom_range(0, 255));
      if (mem_req) begin
        act_reqs++;
        check("mem_addr", 32'(mem_addr), {28'h0, ins[3:0]});
        check("mem_we", 32'(mem_we), 32'(ins[7:4] == 4'hB));
        check("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
      end
      if (state_main == 4'd4) begin
        mem_ready = (waits >= delay);
        if (mem_ready) mem_rdata = rdata;
        waits++;
      end
    end while (state_main != 4'd1 && act_cycles < 40);
    instr_valid = 1'b0;
    mem_ready = 1'b0;
    check("fetch_return", 32'(act_cycles < 40), 32'd1);
  endtask

  initial begin
    exp_t       e;
    logic [31:0] tr;
    logic [7:0]  prev_acc;

    vecs[0]  = '{8'hA3, 8'h80, 0,  8'h80, 2'b00, 8'h01, 1'b0, 7};
    vecs[1]  = '{8'hA0, 8'hF5, 0,  8'hF5, 2'b00, 8'h02, 1'b0, 7};
    vecs[2]  = '{8'h1F, 8'h00, 0,  8'h04, 2'b10, 8'h03, 1'b0, 5};
    vecs[3]  = '{8'h34, 8'h00, 0,  8'h00, 2'b11, 8'h04, 1'b0, 5};
    vecs[4]  = '{8'hB7, 8'h00, 3,  8'h00, 2'b11, 8'h05, 1'b0, 8};
    vecs[5]  = '{8'hD2, 8'h00, 0,  8'h00, 2'b11, 8'h06, 1'b0, 4};
    vecs[6]  = '{8'hCE, 8'h00, 0,  8'h00, 2'b11, 8'h05, 1'b0, 4};
    vecs[7]  = '{8'hC8, 8'h00, 0,  8'h00, 2'b11, 8'hFE, 1'b0, 4};
    vecs[8]  = '{8'h70, 8'h00, 0,  8'h00, 2'b11, 8'hFF, 1'b0, 3};
    vecs[9]  = '{8'hD5, 8'h00, 0,  8'h00, 2'b11, 8'h00, 1'b0, 4};
    vecs[10] = '{8'h15, 8'h00, 0,  8'h05, 2'b00, 8'h01, 1'b0, 5};
    vecs[11] = '{8'h02, 8'hFE, 1,  8'h03, 2'b10, 8'h02, 1'b0, 8};
    vecs[12] = '{8'h23, 8'h05, 0,  8'hFE, 2'b00, 8'h03, 1'b0, 7};
    vecs[13] = '{8'h44, 8'h0F, 0,  8'h0E, 2'b00, 8'h04, 1'b0, 7};
    vecs[14] = '{8'h51, 8'h00, 0,  8'h00, 2'b01, 8'h05, 1'b0, 5};
    vecs[15] = '{8'hC2, 8'h00, 0,  8'h00, 2'b01, 8'h08, 1'b0, 4};
    vecs[16] = '{8'h1F, 8'h00, 0,  8'h0F, 2'b00, 8'h09, 1'b0, 5};
    vecs[17] = '{8'hB9, 8'h00, 0,  8'h0F, 2'b00, 8'h0A, 1'b0, 5};
    vecs[18] = '{8'h06, 8'h77, 99, 8'h0F, 2'b00, 8'h0B, 1'b1, 8};
    vecs[19] = '{8'h11, 8'h00, 0,  8'h10, 2'b00, 8'h0C, 1'b1, 5};
    vecs[20] = '{8'h3F, 8'h00, 0,  8'h01, 2'b10, 8'h0D, 1'b1, 5};

    restart_n = 1'b0;
    instruction = 8'h00;
    instr_valid = 1'b0;
    mem_rdata = 8'h00;
    mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state_main), 32'd0);
    check("rst_acc", 32'(acc), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ctrl", {29'd0, mem_req, mem_we, instr_ready}, 32'd0);
    check("rst_addr_wdata", {16'd0, mem_addr, mem_wdata}, 32'd0);
    restart_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_to_fetch", 32'(state_main), 32'd1);
    check("fetch_ready", 32'(instr_ready), 32'd1);

    for (int i = 0; i < NV; i++) begin
      prev_acc = (i == 0) ? 8'h00 : vecs[i-1].acc;
      e = '{acc: vecs[i].acc, flags: vecs[i].flags, pc: vecs[i].pc, err: vecs[i].err,
            cycles: 8'(vecs[i].cycles), reqs: 2'(is_mem_op(vecs[i].instr[7:4]))};
      exp_q.push_back(e);
      run_instr(vecs[i].instr, vecs[i].rdata, vecs[i].delay, prev_acc);
      e = exp_q.pop_front();
      check($sformatf("v%0d_acc", i), 32'(acc), 32'(e.acc));
      check($sformatf("v%0d_flags", i), 32'(flags), 32'(e.flags));
      check($sformatf("v%0d_pc", i), 32'(pc), 32'(e.pc));
      check($sformatf("v%0d_err", i), 32'(err), 32'(e.err));
      check($sformatf("v%0d_cycles", i), 32'(act_cycles), 32'(e.cycles));
      check($sformatf("v%0d_reqs", i), 32'(act_reqs), 32'(e.reqs));
      if (i == 0) begin
        tr = '0;
        foreach (trace[k]) tr = {tr[27:0], trace[k]};
        check("load_state_trace", tr, 32'h12345691);
      end
    end

    // Reset asserted while a LOAD sits in MEM_WAIT; a late ready must be ignored.
    instruction = 8'hA5;
    instr_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    instr_valid = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    check("mw_state", 32'(state_main), 32'd4);
    restart_n = 1'b0;
    @(posedge clk); @(negedge clk);
    check("mwrst_state", 32'(state_main), 32'd0);
    check("mwrst_acc", 32'(acc), 32'd0);
    check("mwrst_pc", 32'(pc), 32'd0);
    check("mwrst_flags", 32'(flags), 32'd0);
    check("mwrst_err", 32'(err), 32'd0);
    check("mwrst_ctrl", {29'd0, mem_req, mem_we, instr_ready}, 32'd0);
    check("mwrst_addr_wdata", {16'd0, mem_addr, mem_wdata}, 32'd0);
    restart_n = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 8'h55;
    repeat (3) @(negedge clk);
    check("late_ready_state", 32'(state_main), 32'd1);
    check("late_ready_acc", 32'(acc), 32'd0);
    check("late_ready_err", 32'(err), 32'd0);
    mem_ready = 1'b0;

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
